// File: rtl/em_reg_pkg.sv
// Shared constants for the Execute->Memory pipeline register: store opcodes,
// instruction opcode field bounds and the Tnew counter width.
package em_reg_pkg;

    localparam int T_W   = 5;
    localparam int OP_HI = 31;
    localparam int OP_LO = 26;

    localparam logic [5:0] OP_SW = 6'h2b;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SB = 6'h28;

    localparam logic [T_W-1:0] T_ONE = T_W'(1);

    // Tnew counts down toward "result ready" and never wraps.
    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - T_ONE;
    endfunction

endpackage

// File: rtl/store_align.sv
// Store formatting ahead of the E/M register: byte enables, lane replication
// of the store data and misalignment detection.
module store_align
    import em_reg_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  addr,
    input  logic [31:0] rt_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_data,
    output logic        align_err
);

    always_comb begin
        byte_en    = 4'b0000;
        store_data = rt_data;
        align_err  = 1'b0;
        case (opcode)
            OP_SW: begin
                if (addr == 2'd0) byte_en = 4'b1111;
                else              align_err = 1'b1;
            end
            OP_SH: begin
                store_data = {2{rt_data[15:0]}};
                if (addr[0]) align_err = 1'b1;
                else         byte_en = addr[1] ? 4'b1100 : 4'b0011;
            end
            OP_SB: begin
                store_data = {4{rt_data[7:0]}};
                byte_en    = 4'b0001 << addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/em_reg.sv
// Execute->Memory pipeline register with stall/flush, saturating Tnew tracking
// and registered store byte enables for the data memory.
module em_reg
    import em_reg_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    E_alu_res,
    input  logic [31:0]    E_reg_write,
    input  logic [31:0]    E_PC,
    input  logic [31:0]    E_ins,
    input  logic [31:0]    E_rt_data,
    input  logic [4:0]     E_regw_adr,
    input  logic [T_W-1:0] E_T,
    input  logic           stall,
    input  logic           flush,
    output logic [31:0]    M_alu_res,
    output logic [31:0]    M_reg_write,
    output logic [31:0]    M_PC,
    output logic [31:0]    M_ins,
    output logic [31:0]    M_store_data,
    output logic [4:0]     M_regw_adr,
    output logic [T_W-1:0] M_T,
    output logic [3:0]     M_byte_en,
    output logic           M_fwd_valid,
    output logic           M_align_err
);

    logic [3:0]  sa_byte_en;
    logic [31:0] sa_store_data;
    logic        sa_align_err;

    store_align u_store_align (
        .opcode     (E_ins[OP_HI:OP_LO]),
        .addr       (E_alu_res[1:0]),
        .rt_data    (E_rt_data),
        .byte_en    (sa_byte_en),
        .store_data (sa_store_data),
        .align_err  (sa_align_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            M_alu_res    <= '0;
            M_reg_write  <= '0;
            M_PC         <= '0;
            M_ins        <= '0;
            M_store_data <= '0;
            M_regw_adr   <= '0;
            M_T          <= '0;
            M_byte_en    <= '0;
            M_align_err  <= 1'b0;
        end else if (flush) begin
            M_alu_res    <= '0;
            M_reg_write  <= '0;
            M_PC         <= '0;
            M_ins        <= '0;
            M_store_data <= '0;
            M_regw_adr   <= '0;
            M_T          <= '0;
            M_byte_en    <= '0;
            M_align_err  <= 1'b0;
        end else if (stall) begin
            // Payload holds; the producer keeps making progress while stalled.
            M_T <= sat_dec(M_T);
        end else begin
            M_alu_res    <= E_alu_res;
            M_reg_write  <= E_reg_write;
            M_PC         <= E_PC;
            M_ins        <= E_ins;
            M_store_data <= sa_store_data;
            M_regw_adr   <= E_regw_adr;
            M_T          <= sat_dec(E_T);
            M_byte_en    <= sa_byte_en;
            M_align_err  <= sa_align_err;
        end
    end

    assign M_fwd_valid = (M_T == '0) && (M_regw_adr != 5'd0);

endmodule

// File: tb/tb_em_reg.sv
// Directed plus randomized checks of em_reg against an arithmetic reference
// model of the pipeline register.
module tb_em_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] E_alu_res, E_reg_write, E_PC, E_ins, E_rt_data;
    logic [4:0]  E_regw_adr, E_T;
    logic        stall, flush;
    logic [31:0] M_alu_res, M_reg_write, M_PC, M_ins, M_store_data;
    logic [4:0]  M_regw_adr, M_T;
    logic [3:0]  M_byte_en;
    logic        M_fwd_valid, M_align_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] x_alu, x_rw, x_pc, x_ins, x_sd;
    int          x_adr, x_t, x_be, x_err;

    always #5 clk = ~clk;

    em_reg dut (
        .clk(clk), .reset(reset),
        .E_alu_res(E_alu_res), .E_reg_write(E_reg_write), .E_PC(E_PC),
        .E_ins(E_ins), .E_rt_data(E_rt_data), .E_regw_adr(E_regw_adr), .E_T(E_T),
        .stall(stall), .flush(flush),
        .M_alu_res(M_alu_res), .M_reg_write(M_reg_write), .M_PC(M_PC),
        .M_ins(M_ins), .M_store_data(M_store_data), .M_regw_adr(M_regw_adr),
        .M_T(M_T), .M_byte_en(M_byte_en), .M_fwd_valid(M_fwd_valid),
        .M_align_err(M_align_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        x_alu = 0; x_rw = 0; x_pc = 0; x_ins = 0; x_sd = 0;
        x_adr = 0; x_t = 0; x_be = 0; x_err = 0;
    endtask

    task automatic model_edge();
        int a;
        if (flush) model_zero();
        else if (stall) x_t = (x_t > 0) ? x_t - 1 : 0;
        else begin
            a     = int'(E_alu_res % 4);
            x_alu = E_alu_res; x_rw = E_reg_write; x_pc = E_PC; x_ins = E_ins;
            x_adr = int'(E_regw_adr);
            x_t   = (E_T > 0) ? int'(E_T) - 1 : 0;
            x_sd  = E_rt_data; x_be = 0; x_err = 0;
            if (E_ins[31:26] == 6'h2b) begin
                if (a == 0) x_be = 15; else x_err = 1;
            end else if (E_ins[31:26] == 6'h29) begin
                x_sd = E_rt_data[15:0] * 32'h0001_0001;
                if (a % 2 == 0) x_be = 3 << a; else x_err = 1;
            end else if (E_ins[31:26] == 6'h28) begin
                x_sd = E_rt_data[7:0] * 32'h0101_0101;
                x_be = 1 << a;
            end
        end
    endtask

    task automatic check_all();
        chk("alu_res",    M_alu_res,    x_alu);
        chk("reg_write",  M_reg_write,  x_rw);
        chk("pc",         M_PC,         x_pc);
        chk("ins",        M_ins,        x_ins);
        chk("store_data", M_store_data, x_sd);
        chk("regw_adr",   32'(M_regw_adr), 32'(x_adr));
        chk("t",          32'(M_T),      32'(x_t));
        chk("byte_en",    32'(M_byte_en), 32'(x_be));
        chk("align_err",  32'(M_align_err), 32'(x_err));
        chk("fwd_valid",  32'(M_fwd_valid), (x_t == 0 && x_adr != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] rt,
                         input logic [4:0] adr, input logic [4:0] t);
        E_ins       = {op, 26'($urandom)};
        E_alu_res   = alu;
        E_rt_data   = rt;
        E_regw_adr  = adr;
        E_T         = t;
        E_reg_write = $urandom;
        E_PC        = $urandom;
    endtask

    initial begin
        logic [31:0] held_ins;
        logic [5:0]  ops [6];
        ops = '{6'h2b, 6'h29, 6'h28, 6'h23, 6'h00, 6'h0f};

        // Asynchronous reset with nonzero inputs, no clock edge in between.
        stall = 0; flush = 0; reset = 1;
        drive(6'h2b, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7, 5'd3);
        #3 reset = 0;
        #1 model_zero();
        check_all();
        #2 reset = 1;

        // sb to byte 3
        drive(6'h28, 32'h0000_0013, 32'h1234_56AB, 5'd0, 5'd1);
        tick();
        chk("sb_be",   32'(M_byte_en), 32'h8);
        chk("sb_data", M_store_data, 32'hABAB_ABAB);

        // misaligned sw
        drive(6'h2b, 32'h0000_0006, 32'h5555_AAAA, 5'd0, 5'd1);
        tick();
        chk("sw_mis_err", 32'(M_align_err), 32'd1);

        // sh upper half
        drive(6'h29, 32'h0000_0102, 32'h0000_BEEF, 5'd0, 5'd1);
        tick();
        chk("sh_hi_be", 32'(M_byte_en), 32'hC);

        // Tnew countdown through a two-cycle stall
        drive(6'h00, 32'h1111_2222, 32'h3333_4444, 5'd5, 5'd2);
        tick();
        chk("t_load", 32'(M_T), 32'd1);
        held_ins = M_ins;
        stall = 1;
        tick();
        chk("t_stall1", 32'(M_T), 32'd0);
        chk("fwd_at_0", 32'(M_fwd_valid), 32'd1);
        tick();
        chk("t_stall2", 32'(M_T), 32'd0);
        chk("ins_held", M_ins, held_ins);

        // stall and flush together -> bubble
        flush = 1;
        tick();
        chk("bubble_fwd", 32'(M_fwd_valid), 32'd0);
        flush = 0; stall = 0;

        // r0 destination never forwards
        drive(6'h00, 32'h0, 32'h0, 5'd0, 5'd0);
        tick();
        chk("r0_fwd", 32'(M_fwd_valid), 32'd0);

        // reset mid-stall, then normal loading after release
        drive(6'h28, 32'h0000_0001, 32'h0000_00CD, 5'd9, 5'd4);
        tick();
        stall = 1;
        tick();
        #2 reset = 0;
        #1 model_zero();
        check_all();
        reset = 1;
        stall = 0;
        drive(6'h29, 32'h0000_0000, 32'h0000_1234, 5'd3, 5'd0);
        tick();

        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive(ops[$urandom_range(0, 5)], $urandom, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 4)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
